// File: rtl/serial_byte_rx.sv
// Serial frame receiver: start(0), 8 data bits LSB first, stop(1) on an idle-high line.
// Emits the assembled byte with a one-cycle valid strobe, or a one-cycle frame_err on a bad stop bit.
module serial_byte_rx #(
  parameter int BIT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int H  = BIT_CYCLES / 2;
  localparam int CW = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic          rx_q1;
  logic          rx_s;

  assign busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values,
  // which is what makes rx_q1 -> rx_s a true two-stage synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_q1     <= rx;
      rx_s      <= rx_q1;
      // Strobes default low so each fires for exactly the one cycle it is set.
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cyc_cnt <= '0;
          end
        end

        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            // A start bit that is high again at its midpoint was only a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            sh      <= {rx_s, sh[7:1]};
            cyc_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
            if (rx_s) begin
              data  <= sh;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_byte_rx.md
# serial_byte_rx

Serial-to-parallel frame receiver for the midterm datapath. It is the receiving end of the byte link whose transmitter parallel-loads an 8-bit word into a shift register and shifts it out on one wire. It takes an asynchronous idle-high line framed as start(0), 8 data bits LSB first, and stop(1). It re-assembles the byte and presents it with a one-cycle valid strobe, flagging bad stop bits.

## Interface
- BIT_CYCLES, 16, clk cycles per serial bit; must be even and ≥ 4.
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly framed byte; bit 0 = first data bit received.
- valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Input sync: rx passes through two flops, giving rx_s. Both flops reset to 1.
- Internal state:
  - cyc_cnt: counts 0..BIT_CYCLES-1.
  - bit_cnt: counts 0..7.
  - 8-bit shift register sh: shifts right, new bit enters bit 7.
- Let H = BIT_CYCLES/2.
- IDLE: if rx_s = 0, go to START with cyc_cnt = 0. Otherwise stay.
- START: increment cyc_cnt. At the edge where cyc_cnt = H-1 (mid start bit):
  - rx_s = 0: go to DATA with cyc_cnt = 0 and bit_cnt = 0.
  - rx_s = 1: false start; go to IDLE with no output activity.
- DATA: increment cyc_cnt. At the edge where cyc_cnt = BIT_CYCLES-1:
  - sh ← {rx_s, sh[7:1]} and cyc_cnt ← 0.
  - If bit_cnt = 7, go to STOP. Otherwise bit_cnt ← bit_cnt + 1.
- STOP: increment cyc_cnt. At the edge where cyc_cnt = BIT_CYCLES-1, go to IDLE and:
  - rx_s = 1: data ← sh and valid = 1 for one cycle.
  - rx_s = 0: frame_err = 1 for one cycle; data keeps its previous value.
- valid and frame_err are never high together, and each is high for exactly one cycle.
- data holds its value until the next good frame.
- No back-pressure. A consumer that misses the valid pulse loses the byte.
- Line held low (break): every frame yields frame_err. IDLE re-detects the low line on the cycle after STOP, so frame_err repeats every 1 + H + 9·BIT_CYCLES cycles.
- Line changes between sample points are ignored. Only mid-bit samples matter.

## Timing
- Reset values: data = 8'h00, valid = 0, frame_err = 0, busy = 0, state = IDLE, counters = 0, sync flops = 1.
- Reset during a frame: at the next edge everything returns to reset values. The partial byte is discarded and no valid or frame_err pulse is emitted.
- rst has priority over every other event.
- Latency: let E0 be the first edge that samples rx = 0 at the start bit.
  - busy rises after edge E0+2.
  - Data bit k is sampled at edge E0+2+H+(k+1)·BIT_CYCLES.
  - valid or frame_err is high after edge E0+2+H+9·BIT_CYCLES, for one cycle.
  - busy falls after that same edge.
- Defaults (BIT_CYCLES = 16): 154 cycles from E0 to valid.
- Test value (BIT_CYCLES = 4): 40 cycles from E0 to valid.
- Back-to-back frames: a new start bit may begin immediately after the stop bit's sample point. The minimum frame spacing is 1 + H + 9·BIT_CYCLES cycles, so full line rate sustains.

## Test plan
All scenarios use BIT_CYCLES = 4, with rx driven 4 clk cycles per bit.
- Reset, then rx idle high for 20 cycles -> data = 00, valid, frame_err and busy stay 0 throughout.
- Send byte A5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> valid pulses exactly 40 cycles after E0, data = A5, busy high for 38 cycles, no frame_err.
- Send 3C then C3 back-to-back with no idle gap -> two valid pulses 40 cycles apart, data = 3C then C3.
- Send 5A with the stop bit driven 0 -> frame_err pulses at cycle 40, valid stays 0, data keeps the previous value.
- Glitch: rx low for 1 cycle, then high -> returns to IDLE without pulses. Separately, assert rst mid-DATA of an FF frame -> next cycle busy = 0 and data = 00; a following 81 frame is received correctly.
